// File: rtl/tp_ntt_stage_mc.sv
// Multi-channel (RNS) radix-2 NTT stage: forward CT / inverse GS butterflies over TP lanes per beat.
// Optional NTT_STAGE_SCALE_EN adds a halving stage (x * 2^-1 mod q) to inverse-mode outputs.

module tp_ntt_bfly #(
    parameter int LOGQ = 32,
    parameter int LAT  = 4,
    parameter int XS   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            inv,
    input  logic [LOGQ-1:0] q,
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    input  logic [LOGQ-1:0] w,
    output logic [LOGQ-1:0] x,
    output logic [LOGQ-1:0] y
);
    localparam int DEPTH = LAT + XS;

    function automatic logic [LOGQ-1:0] add_mod(input logic [LOGQ-1:0] m, n, qq);
        logic [LOGQ:0] s;
        s = {1'b0, m} + {1'b0, n};
        if (s >= {1'b0, qq}) s = s - {1'b0, qq};
        return s[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] m, n, qq);
        logic [LOGQ:0] d;
        d = {1'b0, m} - {1'b0, n};
        if (d[LOGQ]) d = d + {1'b0, qq};
        return d[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] mul_mod(input logic [LOGQ-1:0] m, n, qq);
        logic [2*LOGQ-1:0] p;
        logic [2*LOGQ-1:0] r;
        p = {{LOGQ{1'b0}}, m} * {{LOGQ{1'b0}}, n};
        // q=0 is a don't-care operand; return 0 rather than divide by zero
        r = (qq == '0) ? '0 : p % {{LOGQ{1'b0}}, qq};
        return LOGQ'(r);
    endfunction

    function automatic logic [LOGQ-1:0] half_mod(input logic [LOGQ-1:0] m, qq);
        logic [LOGQ:0] h;
        h = m[0] ? ({1'b0, m} + {1'b0, qq}) : {1'b0, m};
        return h[LOGQ:1];
    endfunction

    logic [LOGQ-1:0] u2, v2, w2;
    logic [LOGQ-1:0] xp [3:DEPTH];
    logic [LOGQ-1:0] yp [3:DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            u2 <= '0;
            v2 <= '0;
            w2 <= '0;
            for (int i = 3; i <= DEPTH; i++) begin
                xp[i] <= '0;
                yp[i] <= '0;
            end
        end else if (en) begin
            w2 <= w;
            if (inv) begin
                u2 <= add_mod(a, b, q);
                v2 <= sub_mod(a, b, q);
                xp[3] <= u2;
                yp[3] <= mul_mod(v2, w2, q);
            end else begin
                u2 <= a;
                v2 <= mul_mod(w, b, q);
                xp[3] <= add_mod(u2, v2, q);
                yp[3] <= sub_mod(u2, v2, q);
            end
            for (int i = 4; i <= DEPTH; i++) begin
                xp[i] <= (XS != 0 && i == DEPTH) ? half_mod(xp[i-1], q) : xp[i-1];
                yp[i] <= (XS != 0 && i == DEPTH) ? half_mod(yp[i-1], q) : yp[i-1];
            end
        end
    end

    // forward beats tap out before the halving stage
    assign x = (XS != 0 && inv) ? xp[DEPTH] : xp[LAT];
    assign y = (XS != 0 && inv) ? yp[DEPTH] : yp[LAT];
endmodule

module tp_ntt_stage_mc #(
    parameter int N       = 128,
    parameter int TP      = 8,
    parameter int LOGQ    = 32,
    parameter int NCH     = 2,
    parameter int BTF_LAT = 4,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cfg_op,
    input  logic                   cfg_start,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic                   cfg_inv,
    input  logic [LOGQ-1:0]        q_in,
    input  logic                   tw_valid,
    input  logic [(TP/2)*LOGQ-1:0] tw_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TP*LOGQ-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TP*LOGQ-1:0]     out_data,
    output logic                   frame_done,
    output logic                   busy
);
`ifdef NTT_STAGE_SCALE_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif
    localparam int NB     = N / TP;
    localparam int NP     = TP / 2;
    localparam int CNT_W  = $clog2(NB);
    localparam int ADDR_W = (NCH * NB > 1) ? $clog2(NCH * NB) : 1;
    localparam int DEPTH  = BTF_LAT + XS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_Q, S_LOAD_TW, S_RUN, S_DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [CH_W-1:0]            ch_r;
    logic                       inv_r;
    logic [LOGQ-1:0]            q_reg [NCH];
    logic [LOGQ-1:0]            q_cur;
    logic [CNT_W-1:0]           cnt, ocnt;
    logic [ADDR_W-1:0]          tw_addr;
    logic [NP*LOGQ-1:0]         tw_ram [NCH*NB];
    logic [NP-1:0][LOGQ-1:0]    tw_rd;
    logic [TP-1:0][LOGQ-1:0]    d1;
    logic [TP-1:0][LOGQ-1:0]    res;
    logic [DEPTH:1]             vld_pipe;
    logic                       active, en, accept, xfer, last_out;

    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign en       = active && out_ready;
    assign in_ready = (state == S_RUN) && out_ready;
    assign accept   = in_valid && in_ready;
    assign out_valid = active && ((XS != 0 && inv_r) ? vld_pipe[DEPTH] : vld_pipe[BTF_LAT]);
    assign xfer     = out_valid && out_ready;
    assign last_out = xfer && (ocnt == CNT_W'(NB - 1));
    assign frame_done = (state == S_DRAIN) && last_out;
    assign busy     = (state != S_IDLE);
    assign q_cur    = q_reg[ch_r];
    assign tw_addr  = ADDR_W'(int'(ch_r) * NB + int'(cnt));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (cfg_start) begin
                    case (cfg_op)
                        2'd1:    state_nxt = S_LOAD_TW;
                        2'd2:    state_nxt = S_RUN;
                        2'd3:    state_nxt = S_LOAD_Q;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            S_LOAD_Q:  state_nxt = S_IDLE;
            S_LOAD_TW: if (tw_valid && cnt == CNT_W'(NB - 1)) state_nxt = S_IDLE;
            S_RUN:     if (accept && cnt == CNT_W'(NB - 1)) state_nxt = S_DRAIN;
            S_DRAIN:   if (last_out) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ch_r     <= '0;
            inv_r    <= 1'b0;
            cnt      <= '0;
            ocnt     <= '0;
            vld_pipe <= '0;
            for (int i = 0; i < NCH; i++) q_reg[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    ocnt     <= '0;
                    vld_pipe <= '0;
                    if (cfg_start) begin
                        ch_r  <= (int'(cfg_ch) < NCH) ? cfg_ch : '0;
                        inv_r <= cfg_inv;
                    end
                end
                S_LOAD_Q:  q_reg[ch_r] <= q_in;
                S_LOAD_TW: if (tw_valid) cnt <= cnt + 1'b1;
                S_RUN, S_DRAIN: begin
                    if (accept) cnt <= cnt + 1'b1;
                    if (xfer) ocnt <= ocnt + 1'b1;
                    if (en) vld_pipe <= {vld_pipe[DEPTH-1:1], accept};
                end
                default: ;
            endcase
        end
    end

    // twiddle storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (state == S_LOAD_TW && tw_valid) tw_ram[tw_addr] <= tw_in;
    end

    // stage 1: coefficients and synchronous twiddle read, both addressed at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            d1    <= '0;
            tw_rd <= '0;
        end else if (en) begin
            d1    <= in_data;
            tw_rd <= tw_ram[tw_addr];
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_pair
        tp_ntt_bfly #(.LOGQ(LOGQ), .LAT(BTF_LAT), .XS(XS)) u_bfly (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .inv (inv_r),
            .q   (q_cur),
            .a   (d1[TP-1-2*p]),
            .b   (d1[TP-2-2*p]),
            .w   (tw_rd[NP-1-p]),
            .x   (res[TP-1-2*p]),
            .y   (res[TP-2-2*p])
        );
    end

    assign out_data = res;
endmodule

// File: tb/tb_tp_ntt_stage_mc.sv
// Directed bench for tp_ntt_stage_mc: N=16, TP=4, two channels, hand-computed butterfly results.
module tb_tp_ntt_stage_mc;
    localparam int N = 16, TP = 4, LOGQ = 32, NCH = 2, LAT = 4, NB = N / TP;
`ifdef NTT_STAGE_SCALE_EN
    localparam int ILAT = LAT + 1;
    localparam bit SC   = 1'b1;
`else
    localparam int ILAT = LAT;
    localparam bit SC   = 1'b0;
`endif

    typedef logic [TP*LOGQ-1:0]       beat_t;
    typedef logic [(TP/2)*LOGQ-1:0]   tw_t;

    logic clk, rst, cfg_start, cfg_ch, cfg_inv, tw_valid, in_valid, in_ready;
    logic out_valid, out_ready, frame_done, busy;
    logic [1:0] cfg_op;
    logic [LOGQ-1:0] q_in;
    tw_t tw_in;
    beat_t in_data, out_data;

    int errors = 0, checks = 0;
    int cyc = 0, fd_n = 0, fd_at = 0, trk_bad = 0;
    beat_t oq[$];
    int oc[$], ac[$];

    beat_t ch1_in[4], ch1_exp[4];

    tp_ntt_stage_mc #(.N(N), .TP(TP), .LOGQ(LOGQ), .NCH(NCH), .BTF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cfg_op(cfg_op), .cfg_start(cfg_start), .cfg_ch(cfg_ch),
        .cfg_inv(cfg_inv), .q_in(q_in), .tw_valid(tw_valid), .tw_in(tw_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            oq.push_back(out_data);
            oc.push_back(cyc);
        end
        if (in_valid && in_ready) ac.push_back(cyc);
        if (frame_done) begin
            fd_n++;
            fd_at = oq.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic ch, input logic inv, input logic [LOGQ-1:0] q);
        cfg_op = op; cfg_ch = ch; cfg_inv = inv; q_in = q; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        if (op == 2'd3) tick();
    endtask

    task automatic load_tw(input logic ch, input tw_t tws[4]);
        cmd(2'd1, ch, 1'b0, '0);
        for (int k = 0; k < NB; k++) begin
            tw_valid = 1'b1; tw_in = tws[k];
            tick();
        end
        tw_valid = 1'b0;
    endtask

    task automatic run_frame(input logic ch, input logic inv, input beat_t beats[4], input bit rnd, input bit poke);
        int k, g;
        oq.delete(); oc.delete(); ac.delete();
        fd_n = 0; fd_at = 0; trk_bad = 0;
        cmd(2'd2, ch, inv, '0);
        k = 0; g = 0;
        while (g < 400 && (k < NB || busy)) begin
            out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            in_valid  = (k < NB);
            in_data   = (k < NB) ? beats[k] : '0;
            cfg_start = poke && (g == 2);
            cfg_op = 2'd3; q_in = 32'd5; cfg_ch = ch;
            @(negedge clk);
            if (k < NB && in_ready !== out_ready) trk_bad++;
            if (in_valid && in_ready) k++;
            tick();
            g++;
        end
        in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b1;
        checks++;
        if (g >= 400) begin
            errors++;
            $display("FAIL frame_timeout: accepted %0d busy %0b, required %0d beats and idle", k, busy, NB);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    endtask

    task automatic test_load_tw_gaps();
        cmd(2'd3, 1'b1, 1'b0, 32'd17);
        cmd(2'd1, 1'b1, 1'b0, '0);
        for (int k = 0; k < NB; k++) begin
            tw_valid = 1'b0;
            tick();
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL tw_gap_busy beat %0d: got %b required 1", k, busy); end
            tw_valid = 1'b1; tw_in = {32'd2, 32'd2};
            tick();
        end
        tw_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tw_done_idle: busy got %b required 0", busy); end
    endtask

    task automatic test_forward();
        beat_t d[4], e;
        for (int k = 0; k < NB; k++) d[k] = {32'd3, 32'd5, 32'd3, 32'd5};
        e = {32'd13, 32'd10, 32'd13, 32'd10};
        run_frame(1'b1, 1'b0, d, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) begin
            checks += 2;
            if (oq.size() <= k || oq[k] !== e) begin
                errors++; $display("FAIL fwd_data beat %0d: got %h required %h", k, (oq.size() > k) ? oq[k] : '0, e);
            end
            if (oc.size() <= k || ac.size() <= k || oc[k] - ac[k] != LAT) begin
                errors++; $display("FAIL fwd_latency beat %0d: got %0d required %0d", k,
                                   (oc.size() > k && ac.size() > k) ? oc[k] - ac[k] : -1, LAT);
            end
        end
        checks += 2;
        if (fd_n != 1) begin errors++; $display("FAIL fwd_frame_done_count: got %0d required 1", fd_n); end
        if (fd_at != NB) begin errors++; $display("FAIL fwd_frame_done_beat: got %0d required %0d", fd_at, NB); end
    endtask

    task automatic test_inverse();
        beat_t d[4], e;
        for (int k = 0; k < NB; k++) d[k] = {32'd3, 32'd5, 32'd3, 32'd5};
        e = SC ? {32'd4, 32'd15, 32'd4, 32'd15} : {32'd8, 32'd13, 32'd8, 32'd13};
        run_frame(1'b1, 1'b1, d, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) begin
            checks += 2;
            if (oq.size() <= k || oq[k] !== e) begin
                errors++; $display("FAIL inv_data beat %0d: got %h required %h", k, (oq.size() > k) ? oq[k] : '0, e);
            end
            if (oc.size() <= k || ac.size() <= k || oc[k] - ac[k] != ILAT) begin
                errors++; $display("FAIL inv_latency beat %0d: got %0d required %0d", k,
                                   (oc.size() > k && ac.size() > k) ? oc[k] - ac[k] : -1, ILAT);
            end
        end
        checks++;
        if (fd_n != 1 || fd_at != NB) begin
            errors++; $display("FAIL inv_frame_done: got count %0d at %0d required 1 at %0d", fd_n, fd_at, NB);
        end
    endtask

    task automatic test_two_channels();
        tw_t t0[4], t1[4];
        beat_t d0[4], e0;
        for (int k = 0; k < NB; k++) begin
            t0[k] = {32'd3, 32'd5};
            t1[k] = {32'(100 + k), 32'(100 + k)};
            d0[k] = {32'd7, 32'd9, 32'd7, 32'd9};
        end
        e0 = {32'd0, 32'd14, 32'd1, 32'd13};
        cmd(2'd3, 1'b0, 1'b0, 32'd17);
        load_tw(1'b0, t0);
        cmd(2'd3, 1'b1, 1'b0, 32'd257);
        load_tw(1'b1, t1);
        run_frame(1'b0, 1'b0, d0, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (oq.size() <= k || oq[k] !== e0) begin
                errors++; $display("FAIL ch0_data beat %0d: got %h required %h", k, (oq.size() > k) ? oq[k] : '0, e0);
            end
        end
        run_frame(1'b1, 1'b0, ch1_in, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (oq.size() <= k || oq[k] !== ch1_exp[k]) begin
                errors++; $display("FAIL ch1_data beat %0d: got %h required %h", k, (oq.size() > k) ? oq[k] : '0, ch1_exp[k]);
            end
        end
        checks++;
        if (fd_n != 1) begin errors++; $display("FAIL ch1_frame_done_count: got %0d required 1", fd_n); end
    endtask

    task automatic test_cfg_ignored();
        for (int r = 0; r < 2; r++) begin
            run_frame(1'b1, 1'b0, ch1_in, 1'b0, r == 0);
            for (int k = 0; k < NB; k++) begin
                checks++;
                if (oq.size() <= k || oq[k] !== ch1_exp[k]) begin
                    errors++; $display("FAIL cfg_ignored pass %0d beat %0d: got %h required %h", r, k,
                                       (oq.size() > k) ? oq[k] : '0, ch1_exp[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        run_frame(1'b1, 1'b0, ch1_in, 1'b1, 1'b0);
        checks += 3;
        if (oq.size() != NB) begin errors++; $display("FAIL bp_count: got %0d required %0d", oq.size(), NB); end
        if (trk_bad != 0) begin errors++; $display("FAIL bp_in_ready_tracks: got %0d mismatches required 0", trk_bad); end
        if (fd_n != 1) begin errors++; $display("FAIL bp_frame_done: got %0d required 1", fd_n); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (oq.size() <= k || oq[k] !== ch1_exp[k]) begin
                errors++; $display("FAIL bp_data beat %0d: got %h required %h", k, (oq.size() > k) ? oq[k] : '0, ch1_exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int k, g;
        oq.delete(); oc.delete(); ac.delete();
        fd_n = 0;
        cmd(2'd2, 1'b1, 1'b0, '0);
        k = 0; g = 0;
        while (k < 3 && g < 50) begin
            in_valid = 1'b1; in_data = ch1_in[k];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            tick();
            g++;
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
        if (k != 3) begin errors++; $display("FAIL midrst_accepts: got %0d required 3", k); end
        rst = 1'b0;
        repeat (8) tick();
        checks += 2;
        if (fd_n != 0) begin errors++; $display("FAIL midrst_frame_done: got %0d required 0", fd_n); end
        if (oq.size() != 0) begin errors++; $display("FAIL midrst_outputs: got %0d required 0", oq.size()); end
        cmd(2'd3, 1'b1, 1'b0, 32'd257);
        run_frame(1'b1, 1'b0, ch1_in, 1'b0, 1'b0);
        for (int j = 0; j < NB; j++) begin
            checks++;
            if (oq.size() <= j || oq[j] !== ch1_exp[j]) begin
                errors++; $display("FAIL midrst_rerun beat %0d: got %h required %h", j, (oq.size() > j) ? oq[j] : '0, ch1_exp[j]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_op = '0; cfg_start = 1'b0; cfg_ch = 1'b0; cfg_inv = 1'b0; q_in = '0;
        tw_valid = 1'b0; tw_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < NB; k++) ch1_in[k] = {32'd200, 32'd100, 32'd200, 32'd100};
        ch1_exp[0] = {32'd177, 32'd223, 32'd177, 32'd223};
        ch1_exp[1] = {32'd20,  32'd123, 32'd20,  32'd123};
        ch1_exp[2] = {32'd120, 32'd23,  32'd120, 32'd23};
        ch1_exp[3] = {32'd220, 32'd180, 32'd220, 32'd180};

        test_reset();
        test_load_tw_gaps();
        test_forward();
        test_inverse();
        test_two_channels();
        test_cfg_ignored();
        test_back_to_back_backpressure();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
